// File: rtl/arb_rr_lock.sv
// Round-robin arbiter that locks the grant until the granted requester's last beat,
// with a binary and one-hot grant. Define ARB_RR_LOCK_TIMEOUT_EN to force a release after TIMEOUT cycles.

module bin2oht_base #(
  parameter int WIDTH          = 8,
  parameter int IMPLEMENTATION = 0
) (
  input  logic                     vld,
  input  logic [$clog2(WIDTH)-1:0] bin,
  output logic [WIDTH-1:0]         oht
);
  localparam int BW = $clog2(WIDTH);

  generate
    if (IMPLEMENTATION == 0) begin : g_table
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign oht[i] = vld & (bin == BW'(i));
      end
    end else if (IMPLEMENTATION == 1) begin : g_loop
      always_comb begin
        // NOTE: every output gets a default before the loop, so no latch is inferred.
        oht = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (bin == BW'(i)) oht[i] = vld;
        end
      end
    end else if (IMPLEMENTATION == 2) begin : g_power
      localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
      assign oht = vld ? TWO ** bin : '0;
    end else if (IMPLEMENTATION == 3) begin : g_shift
      localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
      assign oht = vld ? ONE << bin : '0;
    end else begin : g_bad_impl
      $fatal(1, "bin2oht_base: IMPLEMENTATION must be 0..3");
    end
  endgenerate
endmodule

module arb_rr_lock #(
  parameter int WIDTH          = 8,
  parameter int IMPLEMENTATION = 0,
  parameter int TIMEOUT        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
  input  logic                     rdy,
  input  logic                     lst,
  output logic                     gnt_vld,
  output logic [$clog2(WIDTH)-1:0] gnt_bin,
  output logic [WIDTH-1:0]         gnt_oht,
  output logic                     tmo
);
  localparam int WIDTH_LOG = $clog2(WIDTH);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $fatal(1, "arb_rr_lock: WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_d;
  logic [WIDTH_LOG-1:0] ptr, ptr_d, ptr_next, base;
  logic [WIDTH_LOG-1:0] bin_d, sel_idx;
  logic                 sel_found;
  logic                 busy, rel, tmo_c, load;

  assign busy    = (state == BUSY);
  assign gnt_vld = busy;
  assign rel     = busy & ((rdy & lst) | tmo_c);
  assign tmo     = tmo_c;

  // Explicit wrap keeps non-power-of-two WIDTH correct.
  assign ptr_next = (gnt_bin == WIDTH_LOG'(WIDTH - 1)) ? '0 : gnt_bin + WIDTH_LOG'(1);

  // In BUSY the selection is only consumed on release, so it can always start at ptr_next.
  assign base = busy ? ptr_next : ptr;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      int idx;
      idx = int'(base) + k;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = WIDTH_LOG'(idx);
      end
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    bin_d   = gnt_bin;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_d = BUSY;
          bin_d   = sel_idx;
          load    = 1'b1;
        end
      end
      BUSY: begin
        if (rel) begin
          ptr_d = ptr_next;
          if (sel_found) begin
            bin_d = sel_idx;
            load  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_bin <= '0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      gnt_bin <= bin_d;
    end
  end

`ifdef ARB_RR_LOCK_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  generate
    if (TIMEOUT < 2) begin : g_bad_timeout
      $fatal(1, "arb_rr_lock: TIMEOUT must be >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt, cnt_d;

  assign tmo_c = busy & ~(rdy & lst) & (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt;
    if (load || rel) cnt_d = '0;
    else if (busy)   cnt_d = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_d;
  end
`else
  assign tmo_c = 1'b0;
`endif

  bin2oht_base #(
    .WIDTH          (WIDTH),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_dec (
    .vld (gnt_vld),
    .bin (gnt_bin),
    .oht (gnt_oht)
  );
endmodule

// File: doc/arb_rr_lock.md
Name:
arb_rr_lock

Overview:
- Round-robin arbiter with transaction lock. It shares one resource (bus, port, datapath) among WIDTH requesters.
- Holds the grant until the granted requester completes a transaction, marked by a last beat accepted by the resource.
- Presents the grant in binary and one-hot form. The one-hot form is produced by the team's bin2oht_base decoder.
- Sits between requester ports and the shared resource's mux/select logic.

Parameters:
- WIDTH, 8, number of requesters; WIDTH >= 2 required (elaboration $fatal otherwise).
- WIDTH_LOG, $clog2(WIDTH), localparam, binary grant width.
- IMPLEMENTATION, 0, forwarded to the bin2oht_base decoder instance (0 table, 1 loop, 2 power, 3 shift).
- TIMEOUT, 16, forced-release limit in cycles; used only with the optional feature; TIMEOUT >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- req  input  WIDTH  request vector, one bit per requester.
- rdy  input  1  resource ready; a beat occurs when gnt_vld & rdy.
- lst  input  1  last beat of the granted transaction; qualified by beat.
- gnt_vld  output  1  grant valid.
- gnt_bin  output  WIDTH_LOG  granted requester index (registered).
- gnt_oht  output  WIDTH  one-hot grant, bin2oht_base(vld=gnt_vld, bin=gnt_bin).
- tmo  output  1  forced-release indication (optional feature; otherwise 0).

Behaviour:
- Interface:
  - Single clock clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, ptr=0, gnt_vld=0, gnt_bin=0, gnt_oht=0, tmo=0, timeout counter=0.
  - Reset mid-transaction drops the grant at the next edge; no release bookkeeping is done.
- Internal state:
  - ptr, WIDTH_LOG bits: the highest-priority index.
  - FSM: IDLE, BUSY.
- Arbitration function:
  - Select the first set bit of req scanning ptr, ptr+1, ... WIDTH-1, 0, ... ptr-1.
  - Combinational; result registered into gnt_bin.
- IDLE:
  - If req != 0: register the selected index into gnt_bin, set gnt_vld=1, go to BUSY.
  - Latency is 1 cycle from req seen to gnt_vld.
  - If req == 0: stay in IDLE.
- BUSY:
  - Grant is locked; gnt_bin is constant and req changes are ignored.
  - Release = beat & lst. rdy=0 with lst=1 is not a release.
  - On release: ptr_next = (gnt_bin == WIDTH-1) ? 0 : gnt_bin+1. The wrap is explicit so non-power-of-two WIDTH works.
  - In the same cycle, arbitrate with ptr_next over the current req.
  - If any request is set, the new grant appears next cycle with no idle gap and the FSM stays in BUSY.
  - Otherwise gnt_vld=0 next cycle and the FSM goes to IDLE.
  - The releasing requester, if still requesting, has the lowest priority; it is re-granted only if it is the sole requester.
- ptr updates only on release; it never changes in IDLE.
- Requester dropping req without lst: protocol violation. The grant is still held without the feature.
- Outputs gnt_vld and gnt_bin are registered; gnt_oht is a pure decode of registers (glitch-free w.r.t. inputs); tmo is defined under Optional Feature.

Optional Feature:
- Macro: ARB_RR_LOCK_TIMEOUT_EN.
- Defined:
  - WIDTH-of-$clog2(TIMEOUT) counter, cleared on every new grant, incremented each BUSY cycle without release.
  - When counter == TIMEOUT-1 and no release occurs that cycle, force a release in that cycle. Same ptr update and re-arbitration as a normal release.
  - tmo=1 combinationally during that cycle only.
- Undefined:
  - No counter; tmo tied 0; TIMEOUT ignored; the grant is held indefinitely.

Test Plan:
- Reset (WIDTH=8):
  - rst=1 for 2 cycles with req=8'hFF → gnt_vld=0, gnt_oht=8'h00.
  - First cycle after rst falls → gnt_vld=0. Next cycle → gnt_bin=0, gnt_oht=8'h01.
- Rotation: req=8'hFF, rdy=1, lst=1 continuously → gnt_bin 0,1,2,...,7,0 on consecutive cycles, gnt_vld never drops.
- Lock: req=8'h05, grant 0 held with rdy=1, lst=0 for 5 cycles → gnt_bin stays 0. Then lst=1 → next cycle gnt_bin=2, gnt_oht=8'h04.
- Wrap and stall:
  - WIDTH=5: grant 4 released with req=5'h11 → next grant 0.
  - lst=1 with rdy=0 → no release, grant unchanged.
  - Release with req=0 → gnt_vld=0 next cycle, FSM in IDLE.
- Timeout, macro defined, TIMEOUT=4: grant 3 with req=8'h18, rdy=0 → tmo=1 in the 4th grant cycle (counter=3). Next cycle gnt_bin=4.
- Timeout, macro undefined: same stimulus → gnt_bin=3 held for 20 cycles, tmo=0.
